// File: rtl/ram_wait_ctrl.sv
// Single-bank on-chip RAM controller: address-window decode, byte-lane write merge,
// and a programmable number of BUSY wait states ahead of a one-cycle DONE handshake.
module ram_wait_ctrl #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_8000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] addr,
  input  logic        wen,
  input  logic [3:0]  byte_en,
  input  logic [31:0] wdata,
  output logic [31:0] ram_rdata,
  output logic        ram_wait,
  output logic        ram_active
);

  localparam int          IW    = $clog2(DEPTH);
  // 33-bit limit so a window ending at 4 GiB does not wrap
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  byte_en;
    logic [31:0] wdata;
  } req_t;

  state_t        state, state_nxt;
  req_t          lat;
  logic [3:0]    cnt;
  logic [31:0]   mem [DEPTH];
  logic          hit, req, start, abort_acc, fire;
  logic [IW-1:0] idx;

  assign hit        = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < LIMIT);
  assign req        = |byte_en;
  assign ram_active = hit & req;
  assign ram_wait   = (state != DONE);
  assign idx        = IW'((lat.addr - BASE_ADDR) >> 2);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    abort_acc = 1'b0;
    fire      = 1'b0;
    case (state)
      IDLE: if (ram_active) begin
        state_nxt = BUSY;
        start     = 1'b1;
      end
      // master changed its mind: drop the access without touching array or rdata
      BUSY: if (!req || addr != lat.addr || wen != lat.wen) begin
        state_nxt = IDLE;
        abort_acc = 1'b1;
      end else if (cnt == 4'd0) begin
        state_nxt = DONE;
        fire      = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      cnt       <= 4'd0;
      lat       <= '0;
      ram_rdata <= 32'h0;
    end else begin
      if (start) begin
        cnt <= 4'(WAIT_STATES);
        lat <= '{addr: addr, wen: wen, byte_en: byte_en, wdata: wdata};
      end else if (state == BUSY && !abort_acc && !fire) begin
        cnt <= cnt - 4'd1;
      end
      if (fire && !lat.wen) ram_rdata <= mem[idx];
    end
  end

  // Array is deliberately not reset
  always_ff @(posedge clk) begin
    if (fire && lat.wen)
      for (int i = 0; i < 4; i++)
        if (lat.byte_en[i]) mem[idx][8*i +: 8] <= lat.wdata[8*i +: 8];
  end

endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Bench for ram_wait_ctrl: one WAIT_STATES=1 and one WAIT_STATES=0 instance on a shared bus,
// expected read data queued at issue time from a per-instance word model.
module tb_ram_wait_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_8000;
  localparam int          DEPTH = 64;

  logic        clk = 1'b0, nRST = 1'b0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        wen = 1'b0;
  logic [3:0]  byte_en = 4'h0;
  logic [31:0] rdata1, rdata0;
  logic        wait1, wait0, act1, act0;

  int          checks = 0, errors = 0;
  logic [31:0] exp_q [$];
  logic [31:0] model [2][DEPTH];
  logic [31:0] last_rd [2];

  always #5 clk = ~clk;

  ram_wait_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .nRST(nRST), .addr(addr), .wen(wen), .byte_en(byte_en), .wdata(wdata),
    .ram_rdata(rdata1), .ram_wait(wait1), .ram_active(act1));

  ram_wait_ctrl #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .nRST(nRST), .addr(addr), .wen(wen), .byte_en(byte_en), .wdata(wdata),
    .ram_rdata(rdata0), .ram_wait(wait0), .ram_active(act0));

  // One complete access on instance sel (1: WAIT_STATES=1, 0: WAIT_STATES=0)
  task automatic access(input bit sel, input logic [31:0] a, input logic w,
                        input logic [3:0] be, input logic [31:0] d, input string nm);
    int n, ws, i;
    logic [31:0] got, exp;
    ws = sel ? 1 : 0;
    i  = int'((a - BASE) >> 2);
    @(negedge clk);
    addr = a; wen = w; byte_en = be; wdata = d;
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model[sel][i][8*b +: 8] = d[8*b +: 8];
    end else begin
      exp_q.push_back(model[sel][i]);
    end
    n = 0;
    do begin @(negedge clk); n++; end while ((sel ? wait1 : wait0) && n < 40);
    checks++;
    if (n != ws + 2) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", nm, n, ws + 2);
    end
    if (!w) begin
      got = sel ? rdata1 : rdata0;
      exp = exp_q.pop_front();
      last_rd[sel] = exp;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s rdata: got %h, expected %h", nm, got, exp);
      end
    end
    byte_en = 4'h0;
    @(negedge clk);
    checks++;
    if ((sel ? wait1 : wait0) !== 1'b1) begin
      errors++;
      $display("FAIL %s done_pulse: ram_wait got %b, expected 1", nm, sel ? wait1 : wait0);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; byte_en = 4'h0; addr = BASE;
    repeat (3) @(negedge clk);
    checks++;
    if (wait1 !== 1'b1 || act1 !== 1'b0 || rdata1 !== 32'h0 || wait0 !== 1'b1 || rdata0 !== 32'h0) begin
      errors++;
      $display("FAIL reset: wait1=%b act1=%b rdata1=%h wait0=%b rdata0=%h, expected 1 0 0 1 0",
               wait1, act1, rdata1, wait0, rdata0);
    end
    nRST = 1'b1;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
  endtask

  task automatic test_write_read();
    access(1, BASE + 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, "wr_full");
    access(1, BASE + 32'h10, 1'b0, 4'hF, 32'h0, "rd_full");
    checks++;
    if (rdata1 !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL rd_full_hold: got %h, expected DEADBEEF", rdata1);
    end
  endtask

  task automatic test_byte_write();
    access(1, BASE + 32'h10, 1'b1, 4'b0010, 32'h0000AA00, "wr_byte1");
    access(1, BASE + 32'h10, 1'b0, 4'hF, 32'h0, "rd_merged");
    checks++;
    if (rdata1 !== 32'hDEADAAEF) begin
      errors++;
      $display("FAIL rd_merged_const: got %h, expected DEADAAEF", rdata1);
    end
    access(1, BASE + 32'h13, 1'b0, 4'b1000, 32'h0, "rd_unaligned");
  endtask

  task automatic test_window();
    logic [31:0] oob [2];
    oob[0] = BASE + 32'(4 * DEPTH);
    oob[1] = BASE - 32'h4;
    access(1, BASE + 32'(4 * DEPTH - 4), 1'b1, 4'hF, 32'hCAFEF00D, "wr_last");
    checks++;
    if (rdata1 !== last_rd[1]) begin
      errors++;
      $display("FAIL rdata_hold_write: got %h, expected %h", rdata1, last_rd[1]);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      addr = oob[k]; wen = 1'b1; byte_en = 4'hF; wdata = 32'hFFFF_FFFF;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        checks++;
        if (act1 !== 1'b0 || wait1 !== 1'b1 || act0 !== 1'b0 || wait0 !== 1'b1) begin
          errors++;
          $display("FAIL oob_%0d cyc%0d: act1=%b wait1=%b act0=%b wait0=%b, expected 0 1 0 1",
                   k, c, act1, wait1, act0, wait0);
        end
      end
      byte_en = 4'h0;
    end
    access(1, BASE + 32'(4 * DEPTH - 4), 1'b0, 4'hF, 32'h0, "rd_last");
  endtask

  task automatic test_abort();
    @(negedge clk);
    addr = BASE + 32'h10; wen = 1'b1; byte_en = 4'hF; wdata = 32'h12345678;
    @(negedge clk);
    byte_en = 4'h0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (wait1 !== 1'b1) begin
        errors++;
        $display("FAIL abort_no_done cyc%0d: ram_wait got %b, expected 1", c, wait1);
      end
    end
    checks++;
    if (rdata1 !== last_rd[1]) begin
      errors++;
      $display("FAIL abort_rdata_hold: got %h, expected %h", rdata1, last_rd[1]);
    end
    access(1, BASE + 32'h10, 1'b0, 4'hF, 32'h0, "rd_after_abort");

    @(negedge clk);
    addr = BASE + 32'h10; wen = 1'b1; byte_en = 4'hF; wdata = 32'h12345678;
    @(negedge clk);
    #2 nRST = 1'b0;
    #1;
    checks++;
    if (wait1 !== 1'b1 || rdata1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid_busy: wait1=%b rdata1=%h, expected 1 00000000", wait1, rdata1);
    end
    byte_en = 4'h0;
    @(negedge clk);
    nRST = 1'b1;
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    access(1, BASE + 32'h10, 1'b0, 4'hF, 32'h0, "rd_after_reset");
  endtask

  task automatic test_back_to_back();
    int n;
    logic [31:0] exp;
    access(0, BASE + 32'h0, 1'b1, 4'hF, 32'h1111_2222, "b2b_wr0");
    access(0, BASE + 32'h4, 1'b1, 4'hF, 32'h3333_4444, "b2b_wr1");
    @(negedge clk);
    addr = BASE; wen = 1'b0; byte_en = 4'hF;
    exp_q.push_back(model[0][0]);
    exp_q.push_back(model[0][1]);
    n = 0;
    do begin @(negedge clk); n++; end while (wait0 && n < 40);
    exp = exp_q.pop_front();
    checks++;
    if (n != 2 || rdata0 !== exp) begin
      errors++;
      $display("FAIL b2b_first: latency %0d rdata %h, expected 2 %h", n, rdata0, exp);
    end
    addr = BASE + 32'h4;
    n = 0;
    do begin @(negedge clk); n++; end while (wait0 && n < 40);
    exp = exp_q.pop_front();
    checks++;
    if (n != 3 || rdata0 !== exp) begin
      errors++;
      $display("FAIL b2b_second: spacing %0d rdata %h, expected 3 %h", n, rdata0, exp);
    end
    byte_en = 4'h0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_write();
    test_window();
    test_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

endmodule
